// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite slave backed by a word RAM, with a fixed number of wait states per OKAY data
// phase, a two-cycle ERROR response for bad transfers and a saturating error counter.
module ahb_lite_ram_slave #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [15:0] ERRCOUNT
);

    localparam int unsigned OFF_BITS = ADDR_BITS + 2;
    localparam int unsigned DEPTH    = 1 << ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_e;

    state_e              state_q, state_d;
    logic [3:0]          wait_q, wait_d;
    logic [OFF_BITS-1:0] addr_q, addr_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic [15:0]         errcnt_q, errcnt_d;

    logic [31:0]         ram [DEPTH];
    logic [31:0]         offset;
    logic                in_range, misaligned, bad, accept, commit;
    logic [3:0]          lane_en;
    logic                unused_hburst;

    // Burst type is irrelevant: every beat is treated as a single transfer.
    assign unused_hburst = ^HBURST;

    // An address below BASE_ADDR wraps to a huge offset, so one check covers both ends.
    assign offset   = HADDR - BASE_ADDR;
    assign in_range = (offset >> OFF_BITS) == 32'h0;

    always_comb begin
        misaligned = 1'b0;
        case (HSIZE)
            3'd1:    misaligned = HADDR[0];
            3'd2:    misaligned = HADDR[1:0] != 2'b00;
            default: misaligned = 1'b0;
        endcase
    end

    assign bad = (HSIZE > 3'd2) | misaligned | ~in_range;

    assign HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2) ||
                       ((state_q == S_DATA) && (wait_q == 4'd0));
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign accept    = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign commit    = (state_q == S_DATA) && (wait_q == 4'd0) && write_q;
    assign ERRCOUNT  = errcnt_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        errcnt_d = errcnt_q;
        case (state_q)
            S_DATA: begin
                if (wait_q != 4'd0) wait_d  = wait_q - 4'd1;
                else                state_d = S_IDLE;
            end
            S_ERR1: begin
                state_d = S_ERR2;
                if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
            end
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A pipelined address phase overrides the return to IDLE.
        if (accept) begin
            addr_d  = offset[OFF_BITS-1:0];
            write_d = HWRITE;
            size_d  = HSIZE[1:0];
            wait_d  = 4'(WAIT_STATES);
            state_d = bad ? S_ERR1 : S_DATA;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            wait_q   <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
            errcnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        case (size_q)
            2'd0:    lane_en = 4'b0001 << addr_q[1:0];
            2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // NOTE: the RAM is deliberately not reset; its contents must survive HRESET and it maps to memory.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) ram[addr_q[OFF_BITS-1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    // Asynchronous read makes a write committed on the previous edge visible immediately.
    assign HRDATA = ((state_q == S_DATA) && (wait_q == 4'd0) && !write_q) ?
                    ram[addr_q[OFF_BITS-1:2]] : 32'h0;

endmodule
